// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - HI/LO register owner and multi-cycle multiply/divide sequencer
// Multiply waits MUL_LAT edges on latched operands; divide is a 32-step restoring divider plus sign fix-up.
module hilo_mdu_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  input  logic        hilo_rd_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] src1_mag, src2_mag;
  logic [63:0] mul_ax, mul_bx, prod;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;

    op_signed = ~req_op_i[0];
    src1_mag  = (op_signed && src1_i[31]) ? -src1_i : src1_i;
    src2_mag  = (op_signed && src2_i[31]) ? -src2_i : src2_i;

    // Extending to 64 bits first makes one unsigned multiplier serve both MULT and MULTU.
    mul_ax = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    mul_bx = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod   = mul_ax * mul_bx;

    // In DIV, quo_q starts as the dividend magnitude and shifts quotient bits in from the right.
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, b_q};
    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          case (req_op_i)
            OP_MULT, OP_MULTU: begin
              a_d     = src1_i;
              b_d     = src2_i;
              sgn_d   = op_signed;
              cnt_d   = 6'd0;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = src1_i;
              b_d     = src2_mag;
              quo_d   = src1_mag;
              rem_d   = 32'd0;
              qneg_d  = op_signed & (src1_i[31] ^ src2_i[31]);
              rneg_d  = op_signed & src1_i[31];
              cnt_d   = 6'd0;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = src1_i;
            OP_MTLO: lo_d = src1_i;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'(MUL_LAT - 1)) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'(DIV_ITERS)) begin
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall_o     = busy_o & (hilo_rd_i | req_valid_i);
  assign done_o      = done_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - self-checking bench for hilo_mdu_ctrl
// Directed steps plus random ops, checked against an arithmetic HI/LO model.
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic [31:0] src1_i, src2_i;
  logic        req_ready_o;
  logic        flush_i;
  logic        hilo_rd_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int vecs = 0;
  int errs = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  hilo_mdu_ctrl #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .src1_i(src1_i), .src2_i(src2_i), .req_ready_o(req_ready_o), .flush_i(flush_i),
    .hilo_rd_i(hilo_rd_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one op, from plain integer arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int                sa, sb;
    longint            la, lb;
    longint unsigned   ua, ub;
    logic [63:0]       p;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin la = sa; lb = sb; p = la * lb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin ua = a; ub = b; p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin
        if (b == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo_m = 32'h8000_0000; hi_m = 0; end
        else begin lo_m = sa / sb; hi_m = sa % sb; end
      end
      3'd3: begin
        if (b == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit rd_hold);
    int lat;
    bit got;
    bit rd;
    lat = 0;
    got = 0;
    chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_op_i = op; src1_i = a; src2_i = b;
    tick();
    req_valid_i = 1'b0; src1_i = $urandom; src2_i = $urandom;
    model_op(op, a, b);
    if (op <= 3'd3) begin
      chk({tag, " busy"}, 32'(busy_o), 32'd1);
      for (int c = 1; c <= 60; c++) begin
        tick();
        if (done_o === 1'b1) begin lat = c; got = 1; break; end
        rd = rd_hold ? 1'b1 : 1'($urandom_range(0, 1));
        hilo_rd_i = rd;
        #1;
        chk({tag, " stall"}, 32'(stall_o), 32'(rd));
      end
      chk({tag, " done seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, lat, (op <= 3'd1) ? 32'd2 : 32'd33);
      hilo_rd_i = 1'b1;
      #1;
      chk({tag, " stall in done"}, 32'(stall_o), 32'd0);
      hilo_rd_i = 1'b0;
      chk({tag, " idle at done"}, 32'(busy_o), 32'd0);
    end else begin
      chk({tag, " no done"}, 32'(done_o), 32'd0);
      chk({tag, " no busy"}, 32'(stall_o | busy_o), 32'd0);
    end
    chk({tag, " hi"}, hi_o, hi_m);
    chk({tag, " lo"}, lo_o, lo_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          saw_done;

    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 3'd0; src1_i = 0; src2_i = 0;
    flush_i = 1'b0; hilo_rd_i = 1'b0;
    tick(); tick();
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready after reset", 32'(req_ready_o), 32'd1);

    // 1: moves
    do_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 0);
    do_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 0);
    chk("mthi value", hi_o, 32'h1234_5678);
    chk("mtlo value", lo_o, 32'hCAFE_F00D);

    // 2: multiplies
    do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult hi const", hi_o, 32'hFFFF_FFFF);
    chk("mult lo const", lo_o, 32'hFFFF_FFFA);
    tick();
    chk("done one cycle", 32'(done_o), 32'd0);
    do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    chk("multu hi const", hi_o, 32'h2);

    // 3: divides
    do_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div lo const", lo_o, 32'hFFFF_FFFD);
    chk("div hi const", hi_o, 32'hFFFF_FFFF);
    do_op("divu", 3'd3, 32'd100, 32'd7, 0);
    chk("divu lo const", lo_o, 32'd14);
    do_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // 4: divide by zero with MFHI held
    do_op("div by 0", 3'd2, 32'h55, 32'd0, 1);
    chk("div0 lo const", lo_o, 32'hFFFF_FFFF);
    do_op("div by 0 neg", 3'd2, 32'hFFFF_FF00, 32'd0, 0);

    // illegal op ignored
    req_valid_i = 1'b1; req_op_i = 3'd6; src1_i = $urandom;
    tick();
    req_valid_i = 1'b0;
    chk("illegal busy", 32'(busy_o), 32'd0);
    chk("illegal hi", hi_o, hi_m);
    chk("illegal lo", lo_o, lo_m);

    // 5: flush mid-divide, then flush against MTLO
    req_valid_i = 1'b1; req_op_i = 3'd2; src1_i = 32'd1000; src2_i = 32'd3;
    tick();
    req_valid_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush hi", hi_o, hi_m);
    chk("flush lo", lo_o, lo_m);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) saw_done = 1;
      tick();
    end
    chk("flush no done", 32'(saw_done), 32'd0);
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 3'd5; src1_i = 32'hDEAD_BEEF;
    tick();
    flush_i = 1'b0; req_valid_i = 1'b0;
    chk("flush mtlo lo", lo_o, lo_m);
    chk("flush mtlo busy", 32'(busy_o), 32'd0);

    // 6: reset mid-divide, then back-to-back div -> mult
    do_op("pre mthi", 3'd4, 32'hA5A5_0001, 32'd0, 0);
    req_valid_i = 1'b1; req_op_i = 3'd2; src1_i = 32'd77; src2_i = 32'd5;
    tick();
    req_valid_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst lo", lo_o, 32'd0);
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    tick();
    rst_n = 1'b1;
    tick();
    do_op("b2b div", 3'd2, 32'hFFFF_FC18, 32'd7, 0);
    do_op("b2b mult", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0);

    // random mix
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = rb >> $urandom_range(0, 31);
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op("random", rop, ra, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
